// File: rtl/lockin_pkg.sv
// Shared definitions for the lock-in I/Q demodulator: FSM state encoding,
// the chopper phase-0 reference pattern and the accumulator width rule.
package lockin_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ACQ   = 2'd2
  } state_t;

  // {ref_i, ref_q} value at chopper phase 0; every window starts here.
  localparam logic [1:0] PHASE0 = 2'b00;

  // Sample sign bit + one bit for the negated full-scale value
  // + log2 of the window length guarantees the sum cannot overflow.
  function automatic int acc_w(input int data_w, input int log2_n);
    return data_w + 1 + log2_n;
  endfunction

endpackage

// File: rtl/lockin_demod_acc.sv
// Single-channel sign-select, accumulate and dump for the lock-in
// demodulator. Stage 1 registers +/-sample according to the reference
// level; stage 2 accumulates and, on the window's last product, dumps
// the result and restarts from zero.
// Build option: LOCKIN_DEMOD_AVG_EN turns the dumped sum into the
// rounded (half-up) window mean; latency and widths are unchanged.
module lockin_demod_acc
  import lockin_pkg::*;
#(
  parameter  int DATA_W = 12,
  parameter  int LOG2_N = 2,
  localparam int ACC_W  = acc_w(DATA_W, LOG2_N)
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     clear,      // discard partial window
  input  logic                     load,       // capture this cycle's product
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     ref_bit,
  input  logic                     acc_valid,  // stage-2 product is live
  input  logic                     acc_last,   // stage-2 product ends window
  output logic signed [ACC_W-1:0]  result
);

  localparam int PROD_W = DATA_W + 1;

  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] prod_d;
  logic signed [PROD_W-1:0] prod_r;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  dump;

  // One extra bit so negating the most negative sample stays exact.
  assign sample_ext = {sample_in[DATA_W-1], sample_in};
  assign prod_d     = ref_bit ? sample_ext : -sample_ext;
  assign prod_ext   = {{(ACC_W-PROD_W){prod_r[PROD_W-1]}}, prod_r};
  assign sum        = acc + prod_ext;

`ifdef LOCKIN_DEMOD_AVG_EN
  localparam logic signed [ACC_W-1:0] HALF =
    {{(ACC_W-1){1'b0}}, 1'b1} << (LOG2_N - 1);
  logic signed [ACC_W-1:0] rounded;
  assign rounded = sum + HALF;
  assign dump    = rounded >>> LOG2_N;
`else
  assign dump = sum;
`endif

  // Stage 1: register the sign-selected product.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      prod_r <= '0;
    end else if (load) begin
      prod_r <= prod_d;
    end
  end

  // Stage 2: accumulate, dump on the last product and restart from zero.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      result <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (acc_valid) begin
      if (acc_last) begin
        result <= dump;
        acc    <= '0;
      end else begin
        acc <= sum;
      end
    end
  end

endmodule

// File: rtl/lockin_demodulator.sv
// Dual-phase (I/Q) lock-in demodulator. Each accepted sample is multiplied
// by +/-1 per reference and summed over 2^LOG2_N accepted samples; windows
// always begin at chopper phase 0. Results appear two cycles after the
// window's last sample together with a one-cycle out_valid pulse.
// Build option: LOCKIN_DEMOD_AVG_EN outputs the window mean instead of
// the raw sum (see lockin_demod_acc).
//
// Handshake: sample_in is consumed in any cycle where sample_valid=1 and
// the block is accepting (ALIGN at phase 0, or ACQ); there is no back-
// pressure. out_valid is a single-cycle pulse; i_out/q_out hold between
// pulses.
module lockin_demodulator
  import lockin_pkg::*;
#(
  parameter  int DATA_W = 12,
  parameter  int LOG2_N = 2,
  localparam int ACC_W  = acc_w(DATA_W, LOG2_N)
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic                     ref_i,
  input  logic                     ref_q,
  output logic signed [ACC_W-1:0]  i_out,
  output logic signed [ACC_W-1:0]  q_out,
  output logic                     out_valid,
  output logic                     aligned
);

  state_t            state;
  state_t            state_nxt;
  logic [LOG2_N-1:0] count;
  logic              at_phase0;
  logic              take;
  logic              take_last;
  logic              p_valid;
  logic              p_last;
  logic              acc_valid;

  assign at_phase0 = ({ref_i, ref_q} == PHASE0);
  assign take      = en && sample_valid &&
                     (((state == ALIGN) && at_phase0) || (state == ACQ));
  assign take_last = take && (count == {LOG2_N{1'b1}});
  // A product still in flight when en drops is discarded.
  assign acc_valid = p_valid && en;
  assign aligned   = (state == ACQ);

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: leaving en low always returns to IDLE, forcing realignment.
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ALIGN;
        ALIGN:   if (take) state_nxt = ACQ;
        ACQ:     state_nxt = ACQ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Accepted-sample counter within the window; wraps naturally at N.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (take) begin
      count <= count + 1'b1;
    end
  end

  // Pipeline valid/last tags and the result strobe.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      p_valid   <= 1'b0;
      p_last    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      p_valid   <= take;
      p_last    <= take_last;
      out_valid <= acc_valid && p_last;
    end
  end

  lockin_demod_acc #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_acc_i (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .clear     (!en),
    .load      (take),
    .sample_in (sample_in),
    .ref_bit   (ref_i),
    .acc_valid (acc_valid),
    .acc_last  (p_last),
    .result    (i_out)
  );

  lockin_demod_acc #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_acc_q (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .clear     (!en),
    .load      (take),
    .sample_in (sample_in),
    .ref_bit   (ref_q),
    .acc_valid (acc_valid),
    .acc_last  (p_last),
    .result    (q_out)
  );

endmodule

// File: tb/tb_lockin_demodulator.sv
// Testbench for lockin_demodulator (DATA_W=12, LOG2_N=2). Follows the
// LOCKIN_DEMOD_AVG_EN build option when computing expected results.
module tb_lockin_demodulator;

  localparam int DATA_W = 12;
  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;
  localparam int ACC_W  = DATA_W + 1 + LOG2_N;

  localparam int M_IDLE  = 0;
  localparam int M_ALIGN = 1;
  localparam int M_ACQ   = 2;

  // ---------------- clock / reset / DUT ----------------
  logic                     clk_in = 1'b0;
  logic                     rst_n  = 1'b1;
  logic                     en     = 1'b0;
  logic signed [DATA_W-1:0] sample_in = '0;
  logic                     sample_valid = 1'b0;
  logic                     ref_i = 1'b0;
  logic                     ref_q = 1'b0;
  logic signed [ACC_W-1:0]  i_out;
  logic signed [ACC_W-1:0]  q_out;
  logic                     out_valid;
  logic                     aligned;

  always #5 clk_in = ~clk_in;

  lockin_demodulator #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .en           (en),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .ref_i        (ref_i),
    .ref_q        (ref_q),
    .i_out        (i_out),
    .q_out        (q_out),
    .out_valid    (out_valid),
    .aligned      (aligned)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Expected results queued with the cycle on which they must appear.
  logic signed [ACC_W-1:0] exp_i_q[$];
  logic signed [ACC_W-1:0] exp_q_q[$];
  int                      due_q[$];
  int win_i[$];
  int win_q[$];
  int mode   = M_IDLE;
  int cyc    = 0;
  int last_i = 0;
  int last_q = 0;
  bit seen_valid = 0;
  int seen_i = 0;
  int seen_q = 0;

  function automatic int window_result(input int sum);
`ifdef LOCKIN_DEMOD_AVG_EN
    return (sum + (N / 2)) >>> LOG2_N;
`else
    return sum;
`endif
  endfunction

  function automatic void model_reset();
    exp_i_q.delete(); exp_q_q.delete(); due_q.delete();
    win_i.delete(); win_q.delete();
    mode = M_IDLE; last_i = 0; last_q = 0;
  endfunction

  // Apply one cycle's inputs to the model (cycle number = cyc).
  function automatic void model_apply(input bit e, input bit v, input bit ri,
                                      input bit rq, input int s);
    bit accept;
    int si, sq;
    accept = 0;
    if (!e) begin
      mode = M_IDLE;
      win_i.delete(); win_q.delete();
      if (due_q.size() > 0 && due_q[$] == cyc + 1) begin
        void'(due_q.pop_back()); void'(exp_i_q.pop_back()); void'(exp_q_q.pop_back());
      end
    end else if (mode == M_IDLE) begin
      mode = M_ALIGN;
    end else if (mode == M_ALIGN) begin
      if (v && !ri && !rq) begin accept = 1; mode = M_ACQ; end
    end else begin
      accept = v;
    end
    if (accept) begin
      win_i.push_back(ri ? s : -s);
      win_q.push_back(rq ? s : -s);
      if (win_i.size() == N) begin
        si = 0; sq = 0;
        foreach (win_i[k]) begin si += win_i[k]; sq += win_q[k]; end
        exp_i_q.push_back(ACC_W'(window_result(si)));
        exp_q_q.push_back(ACC_W'(window_result(sq)));
        due_q.push_back(cyc + 2);
        win_i.delete(); win_q.delete();
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: check this cycle's outputs against the model, then drive.
  task automatic step(input bit e, input bit v, input bit ri, input bit rq, input int s);
    bit exp_ov;
    @(posedge clk_in); #1;
    cyc++;
    exp_ov = (due_q.size() > 0 && due_q[0] == cyc);
    check("out_valid", int'(out_valid), int'(exp_ov));
    if (exp_ov) begin
      last_i = int'(exp_i_q.pop_front());
      last_q = int'(exp_q_q.pop_front());
      void'(due_q.pop_front());
    end
    if (out_valid) begin
      seen_valid = 1; seen_i = int'(i_out); seen_q = int'(q_out);
    end
    check("i_out", int'(i_out), last_i);
    check("q_out", int'(q_out), last_q);
    check("aligned", int'(aligned), int'(mode == M_ACQ));
    en = e; sample_valid = v; ref_i = ri; ref_q = rq;
    sample_in = DATA_W'(s);
    model_apply(e, v, ri, rq, s);
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1;
    rst_n = 1'b0; en = 1'b0; sample_valid = 1'b0; ref_i = 1'b0; ref_q = 1'b0;
    #1;
    check("rst_i_out", int'(i_out), 0);
    check("rst_q_out", int'(q_out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_aligned", int'(aligned), 0);
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  function automatic bit ph_i(input int j);
    return (j % 4 == 1) || (j % 4 == 2);
  endfunction
  function automatic bit ph_q(input int j);
    return (j % 4 == 2) || (j % 4 == 3);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    int s0, s1, s2, s3;
    int ei, eq;
  } vec_t;
  vec_t vecs[4];

  task automatic feed_window(input vec_t vv, input string name);
    int arr[4];
    arr[0] = vv.s0; arr[1] = vv.s1; arr[2] = vv.s2; arr[3] = vv.s3;
    seen_valid = 0;
    for (int j = 0; j < 4; j++) step(1, 1, ph_i(j), ph_q(j), arr[j]);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check({name, "_valid"}, int'(seen_valid), 1);
    check({name, "_i"}, seen_i, vv.ei);
    check({name, "_q"}, seen_q, vv.eq);
  endtask

  initial begin
`ifdef LOCKIN_DEMOD_AVG_EN
    vecs[0] = '{s0:100,   s1:100,  s2:100,  s3:100,   ei:0,    eq:0};
    vecs[1] = '{s0:-100,  s1:100,  s2:100,  s3:-100,  ei:100,  eq:0};
    vecs[2] = '{s0:-2048, s1:2047, s2:2047, s3:-2048, ei:2048, eq:0};
    vecs[3] = '{s0:-100,  s1:-100, s2:100,  s3:100,   ei:0,    eq:100};
`else
    vecs[0] = '{s0:100,   s1:100,  s2:100,  s3:100,   ei:0,    eq:0};
    vecs[1] = '{s0:-100,  s1:100,  s2:100,  s3:-100,  ei:400,  eq:0};
    vecs[2] = '{s0:-2048, s1:2047, s2:2047, s3:-2048, ei:8190, eq:0};
    vecs[3] = '{s0:-100,  s1:-100, s2:100,  s3:100,   ei:0,    eq:400};
`endif

    // Reset and idle: nothing happens while en=0.
    do_reset();
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 123);

    // Table: DC rejection, in-phase, full scale, quadrature.
    step(1, 0, 0, 0, 0);
    for (int t = 0; t < 4; t++) feed_window(vecs[t], $sformatf("vec%0d", t));

    // Alignment with gaps: en rises in phase 11, window starts at next 00.
    do_reset();
    seen_valid = 0;
    step(1, 1, 1, 1, 50);
    step(1, 1, 0, 1, 60);
    step(1, 1, 0, 0, 100);
    step(1, 0, 1, 1, 999);
    step(1, 1, 1, 0, 200);
    step(1, 0, 0, 0, 999);
    step(1, 0, 0, 1, 999);
    step(1, 1, 1, 1, 300);
    step(1, 1, 0, 1, 500);
    step(1, 0, 0, 0, 0);
    check("gap_early_valid", int'(seen_valid), 0);
    step(1, 0, 0, 0, 0);
    check("gap_valid", int'(seen_valid), 1);
`ifdef LOCKIN_DEMOD_AVG_EN
    check("gap_i", seen_i, -25);
    check("gap_q", seen_q, 125);
`else
    check("gap_i", seen_i, -100);
    check("gap_q", seen_q, 500);
`endif

    // Abort after two samples: no result, outputs hold.
    seen_valid = 0;
    step(1, 1, 0, 0, 700);
    step(1, 1, 1, 0, 700);
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0);
    check("abort_no_valid", int'(seen_valid), 0);
    check("abort_hold_i", int'(i_out), int'(window_result(-100)));
    check("abort_hold_aligned", int'(aligned), 0);
    // Re-enable: realign and produce a correct first result.
    step(1, 1, 1, 1, 333);
    feed_window(vecs[1], "reen");

    // Last sample in flight when en drops: result discarded.
    seen_valid = 0;
    for (int j = 0; j < 4; j++) step(1, 1, ph_i(j), ph_q(j), 77 * (j + 1));
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("drop_inflight", int'(seen_valid), 0);

    // Randomized traffic against the model, with one reset mid-stream.
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 2000; k++) begin
      bit re, rv;
      int rp;
      if (k == 1000) do_reset();
      re = ($urandom_range(0, 99) != 0);
      rv = ($urandom_range(0, 3) != 0);
      rp = $urandom_range(0, 3);
      step(re, rv, rp[1], rp[0], int'($urandom_range(0, 4095)) - 2048);
    end
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
